// File: rtl/lab4_net_pkg.sv
// Shared definitions for the ring network router: port indices, one-hot
// route encodings, message field layout and the route-compute helper.
package lab4_net_pkg;

  // Output port indices, matching the bit order of reqs/grants.
  localparam int unsigned WEST = 0;
  localparam int unsigned EAST = 1;
  localparam int unsigned SELF = 2;

  // One-hot route encodings.
  localparam logic [2:0] ROUTE_NONE = 3'b000;
  localparam logic [2:0] ROUTE_WEST = 3'b001;
  localparam logic [2:0] ROUTE_EAST = 3'b010;
  localparam logic [2:0] ROUTE_SELF = 3'b100;

  // Default 44-bit message layout: {dest, src, opaque, payload}.
  localparam int unsigned MSG_NBITS      = 44;
  localparam int unsigned PAYLOAD_LSB    = 0;
  localparam int unsigned PAYLOAD_NBITS  = 32;
  localparam int unsigned OPAQUE_LSB     = 32;
  localparam int unsigned OPAQUE_NBITS   = 6;
  localparam int unsigned SRC_LSB        = 38;
  localparam int unsigned SRC_NBITS      = 3;
  localparam int unsigned DEST_LSB       = 41;
  localparam int unsigned DEST_NBITS     = 3;

  // Ring distance east from router_id to dest decides the port. The ring
  // size is a power of two, so masking gives the wrapped distance; the
  // half-way tie goes east.
  function automatic logic [2:0] route_compute(input logic [31:0] dest,
                                               input logic [31:0] router_id,
                                               input logic [31:0] num_routers);
    logic [31:0] d;
    d = (dest - router_id) & (num_routers - 32'd1);
    if (d == 32'd0)
      return ROUTE_SELF;
    else if (d <= (num_routers >> 1))
      return ROUTE_EAST;
    else
      return ROUTE_WEST;
  endfunction

endpackage

// File: rtl/lab4_net_input_queue.sv
// Parameterized circular FIFO used as the router input buffer.
// Ports: clk/reset (sync, active-high); enq_val/enq_rdy/enq_msg write side;
// deq_en pops the head; deq_msg is the head entry; count is occupancy;
// empty flags count == 0.
module lab4_net_input_queue #(
  parameter int unsigned p_num_entries = 2,
  parameter int unsigned p_msg_nbits   = 44
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enq_val,
  output logic                                 enq_rdy,
  input  logic [p_msg_nbits-1:0]               enq_msg,
  input  logic                                 deq_en,
  output logic [p_msg_nbits-1:0]               deq_msg,
  output logic [$clog2(p_num_entries+1)-1:0]   count,
  output logic                                 empty
);

  localparam int unsigned CNT_W = $clog2(p_num_entries + 1);
  localparam int unsigned PTR_W = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

  logic [p_msg_nbits-1:0] r_mem [p_num_entries];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;

  logic w_full;
  logic w_enq;
  logic w_deq;

  // Pointer advance with wrap at the (possibly non power-of-two) depth.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(p_num_entries - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == CNT_W'(p_num_entries));
  assign empty   = (r_count == '0);
  // No enqueue into a full queue, even alongside a dequeue.
  assign enq_rdy = !w_full && !reset;
  assign w_enq   = enq_val && enq_rdy;
  assign w_deq   = deq_en && !empty;
  assign deq_msg = r_mem[r_head];
  assign count   = r_count;

  // Storage, pointers and occupancy; storage is cleared so the head never reads X.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem   <= '{default: '0};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_tail] <= enq_msg;
        r_tail        <= f_next_ptr(r_tail);
      end
      if (w_deq)
        r_head <= f_next_ptr(r_head);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lab4_net_router_input_unit.sv
// Router input unit: buffers incoming messages, routes the head message
// around the ring and dequeues it when the requested output grants.
// Ports: clk/reset (sync, active-high); in_val/in_rdy/in_msg upstream
// handshake; reqs one-hot request {self,east,west}; grants from the output
// controllers in the same order; out_msg head message to the crossbar;
// count current occupancy.
module lab4_net_router_input_unit
  import lab4_net_pkg::*;
#(
  parameter int unsigned p_router_id   = 0,
  parameter int unsigned p_num_routers = 8,
  parameter int unsigned p_msg_nbits   = 44,
  parameter int unsigned p_dest_lsb    = 41,
  parameter int unsigned p_num_entries = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_val,
  output logic                               in_rdy,
  input  logic [p_msg_nbits-1:0]             in_msg,
  output logic [2:0]                         reqs,
  input  logic [2:0]                         grants,
  output logic [p_msg_nbits-1:0]             out_msg,
  output logic [$clog2(p_num_entries+1)-1:0] count
);

  localparam int unsigned DEST_W = $clog2(p_num_routers);

  logic [p_msg_nbits-1:0] w_head_msg;
  logic                   w_empty;
  logic [DEST_W-1:0]      w_dest;
  logic [2:0]             w_route;
  logic                   w_deq;

  lab4_net_input_queue #(
    .p_num_entries (p_num_entries),
    .p_msg_nbits   (p_msg_nbits)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (in_val),
    .enq_rdy (in_rdy),
    .enq_msg (in_msg),
    .deq_en  (w_deq),
    .deq_msg (w_head_msg),
    .count   (count),
    .empty   (w_empty)
  );

  // Route depends only on the stored head, so reqs never sees grants.
  assign w_dest  = w_head_msg[p_dest_lsb +: DEST_W];
  assign w_route = route_compute(32'(w_dest), 32'(p_router_id), 32'(p_num_routers));
  assign reqs    = (w_empty || reset) ? ROUTE_NONE : w_route;
  // Only a grant on the requested port pops the head.
  assign w_deq   = |(reqs & grants);
  assign out_msg = w_head_msg;

endmodule
